// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor split into STAGES carry chunks.
// Each stage adds one CW-bit chunk and registers its carry for the next stage.
// Not-yet-added operand bits and finished result bits travel in per-stage skew
// registers. A global stall (advance) freezes every stage register, so beats
// never reorder, drop or duplicate.
//
// Optional feature: define PIPE_ADDER_SAT_EN to saturate the result on signed
// overflow. Saturation is applied in the final stage, so latency is unchanged.
// Without the macro the result wraps modulo 2^WIDTH.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready = advance, combinational)
//   a, b, sub           operands; sub=1 computes a + ~b + 1
//   out_valid/out_ready result handshake
//   result              registered sum/difference
//   flag_n/z/c/v        registered negative, zero, carry-out, signed overflow
module pipelined_add_sub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned CW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
  end

  // Whole pipe moves together; it may move whenever the output slot is free.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added on entry to stage k, and result bits
    // finished after stage k.
    localparam int unsigned REM  = WIDTH - k * CW;
    localparam int unsigned DONE = (k + 1) * CW;

    logic [REM-1:0]  a_in;
    logic [REM-1:0]  b_in;
    logic            c_in;
    logic            z_in;
    logic            vld_in;
    logic [DONE-1:0] acc_d;
    logic [CW:0]     csum;
    logic            z_d;

    if (k == 0) begin : g_src
      // Subtract is a + ~b + 1: invert b once here, carry-in of 1 below.
      assign a_in   = a;
      assign b_in   = sub ? ~b : b;
      assign c_in   = sub;
      assign z_in   = 1'b1;
      assign vld_in = in_valid;
      assign acc_d  = csum[CW-1:0];
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_reg.a_q;
      assign b_in   = g_stage[k-1].g_reg.b_q;
      assign c_in   = g_stage[k-1].g_reg.c_q;
      assign z_in   = g_stage[k-1].g_reg.z_q;
      assign vld_in = g_stage[k-1].g_reg.vld_q;
      assign acc_d  = {csum[CW-1:0], g_stage[k-1].g_reg.acc_q};
    end

    // One chunk of the carry chain; csum[CW] is the chunk carry-out.
    assign csum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + (CW+1)'(c_in);
    // Zero detect accumulates one chunk per stage.
    assign z_d  = z_in & (csum[CW-1:0] == '0);

    if (k < STAGES - 1) begin : g_reg
      logic                vld_q;
      logic                c_q;
      logic                z_q;
      logic [REM-CW-1:0]   a_q;
      logic [REM-CW-1:0]   b_q;
      logic [DONE-1:0]     acc_q;

      // Intermediate stage: carry, partial zero, skewed operands and result.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          z_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (advance) begin
          vld_q <= vld_in;
          c_q   <= csum[CW];
          z_q   <= z_d;
          a_q   <= a_in[REM-1:CW];
          b_q   <= b_in[REM-1:CW];
          acc_q <= acc_d;
        end
      end
    end else begin : g_out
      logic             c_msb;
      logic             ovf;
      logic [WIDTH-1:0] res_d;
      logic             z_fin;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      assign c_msb = csum[CW-1] ^ a_in[CW-1] ^ b_in[CW-1];
      assign ovf   = c_msb ^ csum[CW];

`ifdef PIPE_ADDER_SAT_EN
      // Saturate toward the sign of A; a saturated value is never zero.
      always_comb begin
        res_d = acc_d;
        z_fin = z_d;
        if (ovf) begin
          res_d = {a_in[CW-1], {(WIDTH-1){~a_in[CW-1]}}};
          z_fin = 1'b0;
        end
      end
`else
      assign res_d = acc_d;
      assign z_fin = z_d;
`endif

      // Final stage doubles as the output register; held while stalled.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_valid <= 1'b0;
          result    <= '0;
          flag_n    <= 1'b0;
          flag_z    <= 1'b1;
          flag_c    <= 1'b0;
          flag_v    <= 1'b0;
        end else if (advance) begin
          out_valid <= vld_in;
          result    <= res_d;
          flag_n    <= res_d[WIDTH-1];
          flag_z    <= z_fin;
          flag_c    <= csum[CW];
          flag_v    <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed literal vectors, a backpressure stream,
// mid-stream reset, and a random sweep checked against an arithmetic model.
module tb_pipelined_add_sub;

  localparam int unsigned W   = 64;
  localparam int unsigned S   = 4;
  localparam int unsigned CKW = W + 8;
  localparam int unsigned NR  = 2000;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_n;
  logic         flag_z;
  logic         flag_c;
  logic         flag_v;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] got[$];
  logic [W-1:0] sa[NR];
  logic [W-1:0] sb[NR];
  logic         ss[NR];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  task automatic check(input string nm, input logic [CKW-1:0] act, input logic [CKW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t         m;
    logic [W:0]   full;
    logic [W-1:0] yo;
    yo    = s ? ~y : y;
    full  = {1'b0, x} + {1'b0, yo} + (W+1)'(s);
    m.c   = full[W];
    m.v   = (x[W-1] == yo[W-1]) && (full[W-1] != x[W-1]);
    m.res = full[W-1:0];
`ifdef PIPE_ADDER_SAT_EN
    if (m.v) m.res = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    m.n = m.res[W-1];
    m.z = (m.res == '0);
    return m;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h0000_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Compare process: every cycle with out_valid is checked against the model.
  initial begin : mon
    exp_t          e;
    logic          stall_p;
    logic [W+4:0]  prev;
    stall_p = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        stall_p = 1'b0;
        continue;
      end
      check("in_ready_rule", CKW'(in_ready), CKW'(!out_valid || out_ready));
      if (stall_p)
        check("hold_while_stalled", CKW'({out_valid, result, flag_n, flag_z, flag_c, flag_v}), CKW'(prev));
      if (out_valid) begin
        check("no_spurious_valid", CKW'(q.size() == 0), CKW'(1'b0));
        if (q.size() != 0) begin
          e = q[0];
          check("model_result", CKW'(result), CKW'(e.res));
          check("model_flags_nzcv", CKW'({flag_n, flag_z, flag_c, flag_v}), CKW'({e.n, e.z, e.c, e.v}));
          if (out_ready) begin
            got.push_back(result);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
      stall_p = out_valid && !out_ready;
      prev    = {out_valid, result, flag_n, flag_z, flag_c, flag_v};
    end
  end

  // Single beat on an empty pipe: literal result/flags and exact latency.
  task automatic one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                     input logic [W-1:0] er, input logic [3:0] ef, input string nm);
    int lat;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({nm, "_latency"}, CKW'(lat), CKW'(S));
    check({nm, "_result"}, CKW'(result), CKW'(er));
    check({nm, "_nzcv"}, CKW'({flag_n, flag_z, flag_c, flag_v}), CKW'(ef));
  endtask

  // Stream n beats from sa/sb/ss. mode 0: ready 1,0,1,0 and no bubbles;
  // mode 1: random ready and random input bubbles.
  task automatic stream(input int n, input int mode);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while ((idx < n || q.size() != 0) && cyc < n * 8 + 100) begin
      @(posedge clk); #1;
      out_ready = (mode == 0) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      if (idx < n && (mode == 0 || $urandom_range(0, 4) != 0)) begin
        in_valid = 1'b1;
        a = sa[idx]; b = sb[idx]; sub = ss[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk); #1;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_all_accepted", CKW'(idx), CKW'(n));
    check("stream_drained", CKW'(q.size()), CKW'(0));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    #2;
    check("reset_out_valid", CKW'(out_valid), CKW'(1'b0));
    check("reset_result", CKW'(result), CKW'(0));
    check("reset_nzcv", CKW'({flag_n, flag_z, flag_c, flag_v}), CKW'(4'b0100));
    check("reset_in_ready", CKW'(in_ready), CKW'(1'b1));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed boundary vectors; flags ordered N,Z,C,V.
    one(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000, "t1_chunk_carry");
    one(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0,                   4'b0110, "t2_wrap");
    one(64'h5,                   64'h5, 1'b1, 64'h0,                   4'b0110, "t2_sub_eq");
    one(64'h3,                   64'h5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, "t2_sub_neg");
    one(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 4'b0000, "t_three_chunks");
`ifdef PIPE_ADDER_SAT_EN
    one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001, "t3_sat_pos");
    one(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h8000_0000_0000_0000, 4'b1011, "t3_sat_neg");
`else
    one(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, "t3_ovf_pos");
    one(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, "t3_ovf_neg");
`endif

    // 8 back-to-back beats a=i, b=3i under alternating backpressure.
    for (int i = 0; i < 8; i++) begin
      sa[i] = W'(i); sb[i] = W'(3 * i); ss[i] = 1'b0;
    end
    got.delete();
    stream(8, 0);
    check("t4_count", CKW'(got.size()), CKW'(8));
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("t4_order_value", CKW'(got[i]), CKW'(4 * i));

    // Mid-stream reset: 3 beats accepted, output stalled, then reset.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b0;
      a = W'(100 + i); b = 64'h1; sub = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("t5_pre_valid", CKW'(out_valid), CKW'(1'b1));
    check("t5_pre_result", CKW'(result), CKW'(101));
    #1 reset = 1'b1;
    #1;
    check("t5_async_valid", CKW'(out_valid), CKW'(1'b0));
    check("t5_async_result", CKW'(result), CKW'(0));
    check("t5_async_flag_z", CKW'(flag_z), CKW'(1'b1));
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    one(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 64'h30, 4'b0000, "t5_after_reset");

    // Random sweep with boundary-heavy operands and random flow control.
    for (int i = 0; i < NR; i++) begin
      sa[i] = pick(); sb[i] = pick(); ss[i] = 1'($urandom_range(0, 1));
    end
    stream(NR, 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
